// File: rtl/ucode_issue_ctrl_if.sv
// Sequencer-side bus of the MUL issue controller: launch/abort pulses and latched
// operands out, generated instruction and its live flag back in.
interface ucode_issue_ctrl_if;
  logic [31:0] seq_instr;
  logic        seq_active;
  logic        seq_start;
  logic        seq_abort;
  logic [3:0]  seq_dest;
  logic [3:0]  seq_src;
  logic [15:0] seq_imm;

  modport master (
    input  seq_instr, seq_active,
    output seq_start, seq_abort, seq_dest, seq_src, seq_imm
  );

  modport slave (
    output seq_instr, seq_active,
    input  seq_start, seq_abort, seq_dest, seq_src, seq_imm
  );
endinterface

// File: rtl/ucode_issue_ctrl.sv
// Issue controller: diverts MUL instructions from IF into the microcode sequencer
// and steers the generated instruction stream into ID until the sequence ends.
module ucode_issue_ctrl #(
  parameter logic [6:0]  MUL_OPCODE = 7'b0110011,
  parameter logic [31:0] NOP_INSTR  = 32'hC800_0000,
  parameter int unsigned WAIT_MAX   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        if_instr,
  input  logic               if_valid,
  output logic               if_stall,
  input  logic               flush,
  ucode_issue_ctrl_if.master seq,
  output logic [31:0]        id_instr,
  output logic               id_valid,
  output logic [7:0]         mul_done_cnt,
  output logic               timeout_err
);
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_ACT, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [3:0]    dest_q, dest_d;
  logic [3:0]    src_q, src_d;
  logic [15:0]   imm_q, imm_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  logic is_mul_op;
  logic mul_detect;
  logic wait_expired;

  assign is_mul_op    = (if_instr[31:25] == MUL_OPCODE);
  assign mul_detect   = if_valid && is_mul_op && !flush;
  assign wait_expired = (wait_cnt_q == WW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      src_q      <= '0;
      imm_q      <= '0;
      cnt_q      <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Flush has priority over sequencer activity and over the timeout in every busy state.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    src_d      = src_q;
    imm_d      = imm_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (mul_detect) begin
          dest_d  = if_instr[24:21];
          src_d   = if_instr[20:17];
          imm_d   = if_instr[15:0];
          state_d = START;
        end
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = flush ? DRAIN : WAIT_ACT;
      end
      WAIT_ACT: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (seq.seq_active) begin
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (!seq.seq_active) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_stall      = (state_q != IDLE);
    seq.seq_start = (state_q == START);
    seq.seq_abort = 1'b0;
    id_valid      = 1'b0;
    case (state_q)
      IDLE:     id_valid = if_valid && !flush && !is_mul_op;
      START:    seq.seq_abort = flush;
      WAIT_ACT: begin
        if (flush) begin
          seq.seq_abort = 1'b1;
        end else if (seq.seq_active) begin
          id_valid = 1'b1;
        end else begin
          seq.seq_abort = wait_expired;
        end
      end
      RUN: begin
        if (flush) begin
          seq.seq_abort = 1'b1;
        end else begin
          id_valid = seq.seq_active;
        end
      end
      default: id_valid = 1'b0;
    endcase
    id_instr = NOP_INSTR;
    if (id_valid) begin
      id_instr = (state_q == IDLE) ? if_instr : seq.seq_instr;
    end
  end

  assign seq.seq_dest = dest_q;
  assign seq.seq_src  = src_q;
  assign seq.seq_imm  = imm_q;
  assign mul_done_cnt = cnt_q;
  assign timeout_err  = timeout_q;
endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Bench for ucode_issue_ctrl: a fetch/sequencer environment drives programs and a
// per-MUL timeline model (latency, stall length, forwarded stream) checks the outputs.
module tb_ucode_issue_ctrl;
  localparam logic [6:0]  MUL_OP   = 7'b0110011;
  localparam logic [31:0] NOP      = 32'hC800_0000;
  localparam int          WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_stall;
  logic        flush;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [7:0]  mul_done_cnt;
  logic        timeout_err;

  int checks = 0;
  int passes = 0;

  logic [7:0]  model_cnt = 8'd0;
  bit          exp_timeout = 1'b0;
  bit          idle_flush_en = 1'b0;
  logic [31:0] prog_instr[$];
  int          prog_delay[$];
  int          prog_flush[$];

  ucode_issue_ctrl_if sif();

  ucode_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .flush        (flush),
    .seq          (sif),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .mul_done_cnt (mul_done_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Instruction the sequencer emits at step k: SUB d,d,d for imm 0, else MOV d,s then imm ADDs.
  function automatic logic [31:0] gen(input int k, input logic [3:0] d, input logic [3:0] s,
                                      input logic [15:0] imm);
    if (imm == 16'd0) return {7'h05, d, d, 17'h0};
    if (k == 0) return {7'h0D, d, s, 17'h0};
    return {7'h13, d, d, 1'b0, 16'(k)};
  endfunction

  function automatic logic [31:0] mk_mul(input logic [3:0] d, input logic [3:0] s,
                                         input logic [15:0] imm);
    return {MUL_OP, d, s, 1'b0, imm};
  endfunction

  function automatic logic [31:0] rand_alu();
    logic [31:0] x;
    x = $urandom();
    if (x[31:25] == MUL_OP) x[31] = ~x[31];
    return x;
  endfunction

  task automatic clear_prog();
    prog_instr.delete();
    prog_delay.delete();
    prog_flush.delete();
  endtask

  task automatic add_alu();
    prog_instr.push_back(rand_alu());
    prog_delay.push_back(0);
    prog_flush.push_back(0);
  endtask

  task automatic add_mul(input logic [3:0] d, input logic [3:0] s, input logic [15:0] imm,
                         input int dly, input int fl);
    prog_instr.push_back(mk_mul(d, s, imm));
    prog_delay.push_back(dly);
    prog_flush.push_back(fl);
  endtask

  // Runs the queued program; each MUL carries its sequencer start delay and flush cycle.
  task automatic run_program(input int budget);
    int n, pc, cyc, t, c_d, c_len, c_f, c_end, ne, sq_dly, sq_idx, sq_len, dly_next;
    bit seq_on, c_to, c_fl, sq_busy, is_mul, exp_valid, exp_abort, win, s_start, s_abort;
    logic [31:0] c_ins, exp_ins;
    n = prog_instr.size();
    pc = 0; cyc = 0; t = 0; c_d = 0; c_len = 0; c_f = 0; c_end = 0; ne = 0;
    sq_dly = 0; sq_idx = 0; sq_len = 0; dly_next = 0;
    seq_on = 0; c_to = 0; c_fl = 0; sq_busy = 0; c_ins = '0;
    while ((pc < n || seq_on) && cyc < budget) begin
      if_valid = (pc < n) && ($urandom_range(0, 3) != 0);
      if_instr = (pc < n) ? prog_instr[pc] : 32'h0;
      flush = seq_on ? (t == c_f) : (idle_flush_en && $urandom_range(0, 7) == 0);
      sif.seq_active = sq_busy && sq_dly == 0 && sq_idx < sq_len;
      sif.seq_instr = sif.seq_active ? gen(sq_idx, sif.seq_dest, sif.seq_src, sif.seq_imm)
                                     : $urandom();
      #1;
      is_mul = 1'b0;
      if (!seq_on) begin
        is_mul = if_valid && !flush && if_instr[31:25] == MUL_OP;
        exp_valid = if_valid && !flush && !is_mul;
        checks++; if (if_stall !== 1'b0) $display("[TB] FAIL idle_stall: got %b want 0", if_stall); else passes++;
        checks++; if (sif.seq_start !== 1'b0) $display("[TB] FAIL idle_start: got %b want 0", sif.seq_start); else passes++;
        checks++; if (sif.seq_abort !== 1'b0) $display("[TB] FAIL idle_abort: got %b want 0", sif.seq_abort); else passes++;
        checks++; if (id_valid !== exp_valid) $display("[TB] FAIL idle_valid: got %b want %b", id_valid, exp_valid); else passes++;
        if (exp_valid) begin
          checks++; if (id_instr !== if_instr) $display("[TB] FAIL pass_instr: got %h want %h", id_instr, if_instr); else passes++;
        end
        if (is_mul) begin
          checks++; if (id_instr !== NOP) $display("[TB] FAIL consume_nop: got %h want %h", id_instr, NOP); else passes++;
        end
      end else begin
        exp_abort = c_fl ? (t == c_f) : (c_to && t == WAIT_MAX + 1);
        win = !c_to && t >= 2 + c_d && t < 2 + c_d + c_len && !(c_fl && t >= c_f);
        checks++; if (if_stall !== 1'b1) $display("[TB] FAIL busy_stall t=%0d: got %b want 1", t, if_stall); else passes++;
        checks++; if (sif.seq_start !== (t == 1)) $display("[TB] FAIL start t=%0d: got %b want %b", t, sif.seq_start, t == 1); else passes++;
        checks++; if (sif.seq_abort !== exp_abort) $display("[TB] FAIL abort t=%0d: got %b want %b", t, sif.seq_abort, exp_abort); else passes++;
        checks++; if (id_valid !== win) $display("[TB] FAIL fwd_valid t=%0d: got %b want %b", t, id_valid, win); else passes++;
        if (win) begin
          exp_ins = gen(t - 2 - c_d, c_ins[24:21], c_ins[20:17], c_ins[15:0]);
          checks++; if (id_instr !== exp_ins) $display("[TB] FAIL fwd_instr t=%0d: got %h want %h", t, id_instr, exp_ins); else passes++;
        end
        if (t == 1) begin
          checks++;
          if ({sif.seq_dest, sif.seq_src, sif.seq_imm} !== {c_ins[24:17], c_ins[15:0]})
            $display("[TB] FAIL operands: got %h/%h/%h want %h/%h/%h", sif.seq_dest, sif.seq_src,
                     sif.seq_imm, c_ins[24:21], c_ins[20:17], c_ins[15:0]);
          else passes++;
        end
      end
      s_start = sif.seq_start;
      s_abort = sif.seq_abort;
      if (!seq_on && if_valid && !flush) begin
        if (is_mul) begin
          c_ins = if_instr; c_d = prog_delay[pc]; c_f = prog_flush[pc];
          c_len = (if_instr[15:0] == 16'd0) ? 1 : int'(if_instr[15:0]) + 1;
          c_to  = c_d >= WAIT_MAX;
          ne    = c_to ? WAIT_MAX + 2 : c_d + c_len + 3;
          c_fl  = (c_f >= 2) && (c_f < ne);
          c_end = c_fl ? c_f + 1 : ne;
          if (!c_fl && !c_to) model_cnt = model_cnt + 8'd1;
          if (c_to && !c_fl) exp_timeout = 1'b1;
          dly_next = c_d;
          seq_on = 1'b1;
          t = 0;
        end
        pc++;
      end
      @(posedge clk); #1;
      if (s_abort) sq_busy = 1'b0;
      else if (s_start) begin
        sq_busy = 1'b1; sq_dly = dly_next; sq_idx = 0;
        sq_len = (sif.seq_imm == 16'd0) ? 1 : int'(sif.seq_imm) + 1;
      end else if (sq_busy) begin
        if (sq_dly > 0) sq_dly--;
        else if (sq_idx < sq_len) sq_idx++;
      end
      if (seq_on) begin
        t++;
        if (t > c_end) seq_on = 1'b0;
      end
      cyc++;
    end
    checks++; if (cyc >= budget) $display("[TB] FAIL budget: got %0d cycles want < %0d", cyc, budget); else passes++;
    checks++; if (mul_done_cnt !== model_cnt) $display("[TB] FAIL done_cnt: got %0d want %0d", mul_done_cnt, model_cnt); else passes++;
    checks++; if (timeout_err !== exp_timeout) $display("[TB] FAIL timeout_err: got %b want %b", timeout_err, exp_timeout); else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_instr = 32'h0123_4567; if_valid = 1'b1; flush = 1'b0;
    sif.seq_active = 1'b0; sif.seq_instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if_stall !== 1'b0) $display("[TB] FAIL rst_stall: got %b want 0", if_stall); else passes++;
    checks++; if (sif.seq_start !== 1'b0) $display("[TB] FAIL rst_start: got %b want 0", sif.seq_start); else passes++;
    checks++; if (sif.seq_abort !== 1'b0) $display("[TB] FAIL rst_abort: got %b want 0", sif.seq_abort); else passes++;
    checks++; if (mul_done_cnt !== 8'd0) $display("[TB] FAIL rst_cnt: got %0d want 0", mul_done_cnt); else passes++;
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL rst_timeout: got %b want 0", timeout_err); else passes++;
    checks++; if (sif.seq_dest !== 4'd0) $display("[TB] FAIL rst_dest: got %h want 0", sif.seq_dest); else passes++;
    checks++; if (sif.seq_src !== 4'd0) $display("[TB] FAIL rst_src: got %h want 0", sif.seq_src); else passes++;
    checks++; if (sif.seq_imm !== 16'd0) $display("[TB] FAIL rst_imm: got %h want 0", sif.seq_imm); else passes++;
    checks++; if (id_valid !== 1'b1) $display("[TB] FAIL rst_valid: got %b want 1", id_valid); else passes++;
    checks++; if (id_instr !== 32'h0123_4567) $display("[TB] FAIL rst_instr: got %h want 01234567", id_instr); else passes++;
    rst = 1'b0;
    model_cnt = 8'd0;
    exp_timeout = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    clear_prog();
    idle_flush_en = 1'b1;
    repeat (12) add_alu();
    run_program(200);
  endtask

  task automatic test_mul_basic();
    clear_prog();
    idle_flush_en = 1'b0;
    add_alu();
    add_mul(4'd1, 4'd0, 16'd3, 0, 0);
    add_alu();
    run_program(200);
  endtask

  task automatic test_back_to_back();
    clear_prog();
    idle_flush_en = 1'b0;
    add_mul(4'd1, 4'd1, 16'd0, 0, 0);
    add_mul(4'd2, 4'd3, 16'd1, 1, 0);
    add_mul(4'd7, 4'd4, 16'd2, 3, 0);
    add_alu();
    run_program(300);
  endtask

  task automatic test_flush_run();
    clear_prog();
    idle_flush_en = 1'b0;
    add_mul(4'd1, 4'd0, 16'd3, 0, 5);
    add_alu();
    add_mul(4'd3, 4'd2, 16'd2, 0, 6);
    add_alu();
    run_program(300);
  endtask

  task automatic test_timeout();
    clear_prog();
    idle_flush_en = 1'b0;
    add_mul(4'd2, 4'd1, 16'd2, WAIT_MAX + 2, 0);
    add_alu();
    add_alu();
    run_program(200);
  endtask

  task automatic test_random();
    int dly, imm, ne, f;
    clear_prog();
    idle_flush_en = 1'b1;
    add_mul(4'($urandom()), 4'($urandom()), 16'd2, WAIT_MAX + 1, 0);
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) add_alu();
      else begin
        imm = int'($urandom_range(0, 4));
        dly = int'($urandom_range(0, WAIT_MAX + 1));
        ne  = (dly >= WAIT_MAX) ? WAIT_MAX + 2 : dly + ((imm == 0) ? 1 : imm + 1) + 3;
        f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, ne)) : 0;
        add_mul(4'($urandom()), 4'($urandom()), 16'(imm), dly, f);
      end
    end
    run_program(3000);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] alu;
    alu = rand_alu();
    flush = 1'b0; if_valid = 1'b1; if_instr = mk_mul(4'd5, 4'd2, 16'd6);
    sif.seq_active = 1'b0; sif.seq_instr = 32'h0;
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(posedge clk); #1;
    sif.seq_active = 1'b1; sif.seq_instr = 32'h1234_5678;
    #1;
    checks++; if (id_valid !== 1'b1) $display("[TB] FAIL mid_first_valid: got %b want 1", id_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (if_stall !== 1'b1) $display("[TB] FAIL mid_run_stall: got %b want 1", if_stall); else passes++;
    checks++; if (mul_done_cnt !== model_cnt) $display("[TB] FAIL mid_cnt_before: got %0d want %0d", mul_done_cnt, model_cnt); else passes++;
    checks++; if (timeout_err !== exp_timeout) $display("[TB] FAIL mid_to_before: got %b want %b", timeout_err, exp_timeout); else passes++;
    if_instr = alu; if_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (if_stall !== 1'b0) $display("[TB] FAIL arst_stall: got %b want 0", if_stall); else passes++;
    checks++; if (sif.seq_start !== 1'b0) $display("[TB] FAIL arst_start: got %b want 0", sif.seq_start); else passes++;
    checks++; if (sif.seq_abort !== 1'b0) $display("[TB] FAIL arst_abort: got %b want 0", sif.seq_abort); else passes++;
    checks++; if (mul_done_cnt !== 8'd0) $display("[TB] FAIL arst_cnt: got %0d want 0", mul_done_cnt); else passes++;
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL arst_timeout: got %b want 0", timeout_err); else passes++;
    checks++; if ({sif.seq_dest, sif.seq_src, sif.seq_imm} !== 24'h0) $display("[TB] FAIL arst_operands: got %h want 0", {sif.seq_dest, sif.seq_src, sif.seq_imm}); else passes++;
    checks++; if (id_valid !== 1'b1) $display("[TB] FAIL arst_valid: got %b want 1", id_valid); else passes++;
    checks++; if (id_instr !== alu) $display("[TB] FAIL arst_instr: got %h want %h", id_instr, alu); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    sif.seq_active = 1'b0;
    model_cnt = 8'd0;
    exp_timeout = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_wrap();
    clear_prog();
    idle_flush_en = 1'b0;
    repeat (255) add_mul(4'($urandom()), 4'($urandom()), 16'd0, 0, 0);
    run_program(6000);
    checks++; if (mul_done_cnt !== 8'd255) $display("[TB] FAIL cnt_at_255: got %0d want 255", mul_done_cnt); else passes++;
    clear_prog();
    add_mul(4'd1, 4'd2, 16'd1, 0, 0);
    run_program(100);
    checks++; if (mul_done_cnt !== 8'd0) $display("[TB] FAIL cnt_wrap: got %0d want 0", mul_done_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mul_basic();
    test_back_to_back();
    test_flush_run();
    test_timeout();
    test_random();
    test_reset_mid_run();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
